stereo_column_feeder: RTL and testbench

- Producer side of the disparity engine's column interface.
- Accepts synchronized left/right 8-bit grayscale pixel streams in raster order.
- Buffers the previous KERNEL_WIDTH-1 rows per camera and emits one vertical KERNEL_WIDTH-pixel column per camera, tagged with hcount/vcount.
- Paces emission so every column is seen by the disparity engine, using its busy signal; upstream is throttled through a ready handshake.

---
 rtl/stereo_pkg.sv | 22 ++
 rtl/stereo_column_feeder_if.sv | 51 +++++
 rtl/stereo_line_buffer.sv | 40 ++++
 rtl/stereo_column_feeder.sv | 110 +++++++++++
 tb/tb_stereo_column_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stereo_pkg.sv
// Shared types and defaults for the stereo column feeder.
// Frame geometry, pixel/coordinate types and the feeder FSM states.
package stereo_pkg;

  localparam int KERNEL_WIDTH = 3;
  localparam int HRES = 320;
  localparam int VRES = 240;

  typedef logic [7:0] pixel_t;
  typedef logic [9:0] hcount_t;
  typedef logic [8:0] vcount_t;

  typedef pixel_t [KERNEL_WIDTH-1:0] column_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_ARM,
    S_WAIT_BUSY
  } fsm_state_t;

endpackage

// File: rtl/stereo_column_feeder_if.sv
// Pixel-in / column-out bundle between the camera stream,
// the feeder and the disparity engine.
interface stereo_column_feeder_if #(
  parameter int KW = stereo_pkg::KERNEL_WIDTH
);
  import stereo_pkg::*;

  pixel_t          left_pixel_in;
  pixel_t          right_pixel_in;
  hcount_t         hcount_in;
  vcount_t         vcount_in;
  logic            pixel_valid_in;
  logic            pixel_ready_out;
  logic            sad_busy_in;
  pixel_t [KW-1:0] left_column_out;
  pixel_t [KW-1:0] right_column_out;
  hcount_t         hcount_out;
  vcount_t         vcount_out;
  logic            data_valid_out;

  modport master (
    input  left_pixel_in,
    input  right_pixel_in,
    input  hcount_in,
    input  vcount_in,
    input  pixel_valid_in,
    input  sad_busy_in,
    output pixel_ready_out,
    output left_column_out,
    output right_column_out,
    output hcount_out,
    output vcount_out,
    output data_valid_out
  );

  modport slave (
    output left_pixel_in,
    output right_pixel_in,
    output hcount_in,
    output vcount_in,
    output pixel_valid_in,
    output sad_busy_in,
    input  pixel_ready_out,
    input  left_column_out,
    input  right_column_out,
    input  hcount_out,
    input  vcount_out,
    input  data_valid_out
  );

endinterface

// File: rtl/stereo_line_buffer.sv
// Previous KERNEL_WIDTH-1 rows of one camera, one word per column.
// Read returns the old column; the write commits it shifted up by one row.
module stereo_line_buffer
  import stereo_pkg::*;
#(
  parameter int KERNEL_WIDTH = stereo_pkg::KERNEL_WIDTH,
  parameter int HRES         = stereo_pkg::HRES
) (
  input  logic                      clk_in,
  input  logic                      we_in,
  input  hcount_t                   addr_in,
  input  pixel_t                    pixel_in,
  output pixel_t [KERNEL_WIDTH-2:0] rows_out
);

  localparam int AW = $clog2(HRES);
  localparam hcount_t HRES_H = hcount_t'(HRES);

  typedef pixel_t [KERNEL_WIDTH-2:0] rows_t;

  rows_t          mem_q [HRES];
  rows_t          mem_d;
  logic [AW-1:0]  idx;

  always_comb begin
    idx = '0;
    if (addr_in < HRES_H) idx = addr_in[AW-1:0];
    rows_out = mem_q[idx];
    // oldest row drops out, newest pixel enters at the bottom
    for (int k = 0; k < KERNEL_WIDTH - 2; k++) begin
      mem_d[k] = rows_out[k+1];
    end
    mem_d[KERNEL_WIDTH-2] = pixel_in;
  end

  always_ff @(posedge clk_in) begin
    if (we_in) mem_q[idx] <= mem_d;
  end

endmodule

// File: rtl/stereo_column_feeder.sv
// Builds vertical KERNEL_WIDTH-pixel columns per camera and paces
// them against the disparity engine's busy flag.
module stereo_column_feeder
  import stereo_pkg::*;
#(
  parameter int KERNEL_WIDTH = stereo_pkg::KERNEL_WIDTH,
  parameter int HRES         = stereo_pkg::HRES,
  parameter int VRES         = stereo_pkg::VRES
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  stereo_column_feeder_if.master bus
);

  localparam hcount_t HRES_H = hcount_t'(HRES);
  localparam vcount_t VRES_V = vcount_t'(VRES);
  localparam vcount_t FIRST_V = vcount_t'(KERNEL_WIDTH - 1);

  typedef pixel_t [KERNEL_WIDTH-1:0] col_t;

  fsm_state_t state_q, state_d;
  col_t       lcol_q, lcol_d;
  col_t       rcol_q, rcol_d;
  hcount_t    hc_q, hc_d;
  vcount_t    vc_q, vc_d;

  pixel_t [KERNEL_WIDTH-2:0] left_rows;
  pixel_t [KERNEL_WIDTH-2:0] right_rows;

  logic ready;
  logic xfer;
  logic in_range;
  logic we;

  assign ready    = (state_q == S_IDLE) && !bus.sad_busy_in && !rst_in;
  assign xfer     = bus.pixel_valid_in && ready;
  assign in_range = (bus.hcount_in < HRES_H) && (bus.vcount_in < VRES_V);
  assign we       = xfer && in_range;

  stereo_line_buffer #(
    .KERNEL_WIDTH(KERNEL_WIDTH),
    .HRES        (HRES)
  ) u_left_lb (
    .clk_in  (clk_in),
    .we_in   (we),
    .addr_in (bus.hcount_in),
    .pixel_in(bus.left_pixel_in),
    .rows_out(left_rows)
  );

  stereo_line_buffer #(
    .KERNEL_WIDTH(KERNEL_WIDTH),
    .HRES        (HRES)
  ) u_right_lb (
    .clk_in  (clk_in),
    .we_in   (we),
    .addr_in (bus.hcount_in),
    .pixel_in(bus.right_pixel_in),
    .rows_out(right_rows)
  );

  always_comb begin
    state_d = state_q;
    lcol_d  = lcol_q;
    rcol_d  = rcol_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    unique case (state_q)
      S_IDLE: begin
        if (we) begin
          lcol_d = {bus.left_pixel_in, left_rows};
          rcol_d = {bus.right_pixel_in, right_rows};
          hc_d   = bus.hcount_in;
          vc_d   = bus.vcount_in;
          // warm-up rows only fill the buffers
          if (bus.vcount_in >= FIRST_V) state_d = S_EMIT;
        end
      end
      S_EMIT: state_d = S_ARM;
      S_ARM:  state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.sad_busy_in) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      lcol_q  <= '0;
      rcol_q  <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      lcol_q  <= lcol_d;
      rcol_q  <= rcol_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
    end
  end

  assign bus.pixel_ready_out  = ready;
  assign bus.data_valid_out   = (state_q == S_EMIT);
  assign bus.left_column_out  = lcol_q;
  assign bus.right_column_out = rcol_q;
  assign bus.hcount_out       = hc_q;
  assign bus.vcount_out       = vc_q;

endmodule

// File: tb/tb_stereo_column_feeder.sv
// Randomized bench for stereo_column_feeder against a per-column
// history model and a cycles-since-emit pacing model.
module tb_stereo_column_feeder;
  import stereo_pkg::*;

  localparam int KW = 3;
  localparam int CW = KW * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stereo_column_feeder_if #(.KW(KW)) bus ();

  stereo_column_feeder #(
    .KERNEL_WIDTH(KW),
    .HRES        (HRES),
    .VRES        (VRES)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int pulses = 0;
  int ncyc   = 0;
  int pin_hits = 0;
  bit mon_on = 1'b0;
  bit pin_en = 1'b0;
  bit xfer_now = 1'b0;
  bit pulse_now = 1'b0;
  bit eng_en = 1'b0;
  bit rnd_busy = 1'b0;

  // model: cycles since an emitting transfer (-1 = free to accept)
  int since = -1;
  logic [CW-1:0] e_l = '0;
  logic [CW-1:0] e_r = '0;
  bit e_known = 1'b1;
  int e_h = 0;
  int e_v = 0;
  logic [7:0] hl [HRES][KW-1];
  logic [7:0] hr [HRES][KW-1];
  int wc [HRES];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    bit ev, er, x;
    int h, v;
    ev = (since == 1);
    er = !rst && (since < 0) && !bus.sad_busy_in;
    xfer_now  = bus.pixel_valid_in && bus.pixel_ready_out;
    pulse_now = bus.data_valid_out;
    if (mon_on) begin
      ncyc++;
      if (bus.data_valid_out) pulses++;
      chk("ready", longint'(bus.pixel_ready_out), longint'(er));
      chk("valid", longint'(bus.data_valid_out), longint'(ev));
      chk("hcount", longint'(bus.hcount_out), longint'(e_h));
      chk("vcount", longint'(bus.vcount_out), longint'(e_v));
      if (e_known) begin
        chk("left_col", longint'(bus.left_column_out), longint'(e_l));
        chk("right_col", longint'(bus.right_column_out), longint'(e_r));
      end
      if (pin_en && bus.data_valid_out && bus.hcount_out == 10'd5 &&
          bus.vcount_out == 9'd2) begin
        pin_hits++;
        chk("col_h5_v2", longint'(bus.left_column_out), 64'h251505);
      end
      if (pin_en && bus.data_valid_out && bus.hcount_out == 10'd319 &&
          bus.vcount_out == 9'd4) begin
        chk("col_h319_v4", longint'(bus.left_column_out), 64'h7F6F5F);
      end
    end
    x = bus.pixel_valid_in && er;
    h = int'(bus.hcount_in);
    v = int'(bus.vcount_in);
    if (rst) begin
      since = -1;
      e_l = '0;
      e_r = '0;
      e_known = 1'b1;
      e_h = 0;
      e_v = 0;
    end else begin
      if (since == 1 || since == 2) since++;
      else if (since >= 3 && !bus.sad_busy_in) since = -1;
      if (x && h < HRES && v < VRES) begin
        e_known = (wc[h] >= KW - 1);
        for (int k = 0; k < KW - 1; k++) begin
          e_l[k*8 +: 8] = hl[h][k];
          e_r[k*8 +: 8] = hr[h][k];
        end
        e_l[(KW-1)*8 +: 8] = bus.left_pixel_in;
        e_r[(KW-1)*8 +: 8] = bus.right_pixel_in;
        for (int k = 0; k < KW - 2; k++) begin
          hl[h][k] = hl[h][k+1];
          hr[h][k] = hr[h][k+1];
        end
        hl[h][KW-2] = bus.left_pixel_in;
        hr[h][KW-2] = bus.right_pixel_in;
        wc[h]++;
        e_h = h;
        e_v = v;
        if (v >= KW - 1) since = 1;
      end
    end
  end

  // disparity engine stand-in: busy for 11 cycles after each pulse
  initial begin
    int cnt;
    cnt = 0;
    bus.sad_busy_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!eng_en) cnt = 0;
      else if (pulse_now) cnt = 11;
      if (cnt > 0) begin
        bus.sad_busy_in = 1'b1;
        cnt--;
      end else if (rnd_busy) begin
        bus.sad_busy_in = ($urandom_range(0, 3) == 0);
      end else begin
        bus.sad_busy_in = 1'b0;
      end
    end
  end

  task automatic send(input int h, input int v,
                      input logic [7:0] l, input logic [7:0] r);
    int n;
    bus.hcount_in      = hcount_t'(h);
    bus.vcount_in      = vcount_t'(v);
    bus.left_pixel_in  = l;
    bus.right_pixel_in = r;
    bus.pixel_valid_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!xfer_now && n < 100);
    if (!xfer_now) begin
      checks++;
      $display("FAIL send_timeout: no transfer in %0d cycles, h=%0d v=%0d",
               n, h, v);
    end
    #1 bus.pixel_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p0, c0;
    bus.pixel_valid_in = 1'b0;
    bus.left_pixel_in  = '0;
    bus.right_pixel_in = '0;
    bus.hcount_in      = '0;
    bus.vcount_in      = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 mon_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", longint'(bus.pixel_ready_out), 0);
    chk("rst_valid", longint'(bus.data_valid_out), 0);
    chk("rst_hcount", longint'(bus.hcount_out), 0);
    chk("rst_left", longint'(bus.left_column_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_init", longint'(bus.pixel_ready_out), 1);
    @(posedge clk);
    #1;

    pin_en = 1'b1;
    p0 = pulses;
    c0 = ncyc;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < HRES; c++)
        send(c, r, 8'(r * 16 + c), 8'($urandom));
    chk("warmup_cycles", longint'(ncyc - c0), 640);
    idle(4);
    chk("warmup_pulses", longint'(pulses - p0), 0);

    p0 = pulses;
    for (int c = 0; c < HRES; c++) send(c, 2, 8'(2 * 16 + c), 8'($urandom));
    idle(6);
    chk("row2_pulses", longint'(pulses - p0), HRES);
    chk("pin_5_2_seen", longint'(pin_hits), 1);

    eng_en = 1'b1;
    p0 = pulses;
    for (int c = 0; c < HRES; c++) send(c, 3, 8'(3 * 16 + c), 8'($urandom));
    idle(20);
    chk("row3_busy_pulses", longint'(pulses - p0), HRES);

    p0 = pulses;
    send(320, 4, 8'(4 * 16 + 320), 8'($urandom));
    send(0, 240, 8'hAA, 8'h55);
    idle(6);
    chk("drop_no_pulse", longint'(pulses - p0), 0);
    send(319, 4, 8'(4 * 16 + 319), 8'($urandom));
    idle(20);
    chk("h319_pulse", longint'(pulses - p0), 1);
    eng_en = 1'b0;
    pin_en = 1'b0;
    idle(4);

    send(10, 2, 8'h11, 8'h22);
    @(posedge clk);
    p0 = pulses;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", longint'(bus.pixel_ready_out), 1);
    @(posedge clk);
    #1;
    idle(5);
    chk("no_pulse_after_rst", longint'(pulses - p0), 0);
    send(11, 2, 8'h33, 8'h44);
    idle(4);
    chk("pulse_after_rst", longint'(pulses - p0), 1);

    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        eng_en   = ($urandom_range(0, 1) == 1);
        rnd_busy = !eng_en && ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      idle($urandom_range(0, 2));
      send($urandom_range(0, HRES + 7), $urandom_range(0, VRES + 5),
           8'($urandom), 8'($urandom));
    end
    eng_en = 1'b0;
    rnd_busy = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
